// File: rtl/imem_port_arbiter.sv
// rtl/imem_port_arbiter.sv - instruction memory port arbiter: loader boot sequencing, fetch priority, bounded loader starvation
// Optional macro IMEM_ALIGN_CHECK_EN: flag misaligned fetches and suppress misaligned loader writes.
module imem_port_arbiter #(
  parameter int DEPTH      = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [31:0]              ld_addr,
  input  logic [31:0]              ld_data,
  input  logic                     ld_last,
  input  logic                     if_req,
  output logic                     if_ready,
  input  logic [31:0]              if_addr,
  output logic                     if_rvalid,
  output logic [31:0]              if_rdata,
  output logic                     if_err,
  output logic                     core_stall,
  output logic                     mem_we,
  output logic [$clog2(DEPTH)-1:0] mem_addr,
  output logic [31:0]              mem_wdata,
  input  logic [31:0]              mem_rdata
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {BOOT, RUN} state_t;

  state_t        state, state_nxt;
  logic [3:0]    starve_cnt, starve_nxt;
  logic [AW-1:0] last_addr;
  logic [AW-1:0] ld_idx, if_idx;
  logic          ld_oor, if_oor, ld_mis, if_mis, if_bad;

  assign ld_idx = ld_addr[AW+1:2];
  assign if_idx = if_addr[AW+1:2];
  assign ld_oor = |ld_addr[31:AW+2];
  assign if_oor = |if_addr[31:AW+2];

`ifdef IMEM_ALIGN_CHECK_EN
  assign ld_mis = |ld_addr[1:0];
  assign if_mis = |if_addr[1:0];
`else
  logic unused_lsb;
  assign unused_lsb = ^{ld_addr[1:0], if_addr[1:0]};
  assign ld_mis     = 1'b0;
  assign if_mis     = 1'b0;
`endif

  assign if_bad = if_oor || if_mis;

  // Fetch wins in RUN until the loader has been blocked STARVE_MAX cycles in a row
  always_comb begin
    ld_ready   = 1'b0;
    if_ready   = 1'b0;
    state_nxt  = state;
    starve_nxt = starve_cnt;
    if (state == BOOT) begin
      ld_ready = ld_valid;
    end else if (if_req && (starve_cnt < 4'(STARVE_MAX))) begin
      if_ready = 1'b1;
    end else begin
      ld_ready = ld_valid;
    end
    if (ld_ready) begin
      starve_nxt = 4'd0;
      if (ld_last) state_nxt = RUN;
    end else if (ld_valid && (starve_cnt < 4'(STARVE_MAX))) begin
      starve_nxt = starve_cnt + 4'd1;
    end
  end

  assign mem_we     = ld_ready && !ld_oor && !ld_mis;
  assign mem_addr   = ld_ready ? ld_idx : (if_ready ? if_idx : last_addr);
  assign mem_wdata  = ld_ready ? ld_data : 32'd0;
  assign core_stall = (state == BOOT) || (if_req && !if_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= BOOT;
      starve_cnt <= 4'd0;
      last_addr  <= '0;
      if_rvalid  <= 1'b0;
      if_rdata   <= 32'd0;
      if_err     <= 1'b0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      last_addr  <= mem_addr;
      if_rvalid  <= if_ready;
      if_err     <= if_ready && if_bad;
      if (if_ready) if_rdata <= if_bad ? 32'd0 : mem_rdata;
    end
  end
endmodule

// File: doc/imem_port_arbiter.md
# imem_port_arbiter

Sequencer and arbiter for the single-port instruction memory of the single-cycle RISC-V core. It shares the memory's one access port between a program loader, which writes words, and the core's fetch stage, which reads them. It holds the core in a BOOT phase until the program image is loaded, then gives fetch priority with bounded loader starvation. All fetch reads are returned through a registered, one-cycle-latency response path.

## Interface
Parameters:
- DEPTH, 64, instruction memory depth in 32-bit words (power of two).
- STARVE_MAX, 4, consecutive blocked loader cycles in RUN before the loader is forced a grant (1..15).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- ld_valid  in  1  loader write request.
- ld_ready  out  1  loader write accepted this cycle.
- ld_addr  in  32  loader byte address.
- ld_data  in  32  loader write word.
- ld_last  in  1  qualifies the final word of the boot image.
- if_req  in  1  fetch read request.
- if_ready  out  1  fetch request accepted this cycle.
- if_addr  in  32  fetch byte address (PC).
- if_rvalid  out  1  read response valid.
- if_rdata  out  32  read response word.
- if_err  out  1  response error (out-of-range, or misaligned when enabled).
- core_stall  out  1  high when the core must hold PC.
- mem_we  out  1  memory write enable.
- mem_addr  out  log2(DEPTH)  memory word index.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory combinational read data at mem_addr.

## Operation
- Word index = addr[log2(DEPTH)+1:2]. An address is out-of-range when addr[31:log2(DEPTH)+2] is nonzero.
- States:
  - BOOT (reset state): only the loader is granted. if_ready=0, core_stall=1.
  - RUN: the loader may still be granted, for self-modifying code or debug patching.
- BOOT→RUN when a handshake occurs (ld_valid&&ld_ready) with ld_last=1. There is no path from RUN back to BOOT except reset.
- Loader handshake writes: mem_we=1, mem_addr=ld index, mem_wdata=ld_data. An out-of-range loader write is accepted but suppressed (mem_we=0).
- Fetch handshake: mem_addr=if index. On the next edge, if_rdata←mem_rdata (0 if out-of-range), if_rvalid←1, if_err←error flag.
- RUN arbitration:
  - fetch wins when if_req=1 and starve_cnt<STARVE_MAX; otherwise the loader wins if ld_valid=1.
  - starve_cnt increments on each cycle with ld_valid&&!ld_ready, clears on a loader grant, and saturates at STARVE_MAX.
- core_stall = (state==BOOT) || (if_req && !if_ready).
- Exactly one grant per cycle at most. ld_ready and if_ready are never both 1. If neither side requests: mem_we=0, mem_addr holds last value.
- ld_ready and if_ready are combinational from state, requests and starve_cnt.

## Timing
- Reset values: state=BOOT, starve_cnt=0, ld_ready=0, if_ready=0, if_rvalid=0, if_rdata=0, if_err=0, core_stall=1, mem_we=0, mem_addr=0, mem_wdata=0.
- Write latency 0: the memory write occurs on the handshake edge. Read latency 1: if_rvalid is high exactly one cycle after the fetch handshake and is low otherwise.
- A fetch of a word written on edge N, requested in cycle N+1, returns the new data.
- A BOOT→RUN transition on edge N allows if_ready in cycle N+1 at the earliest.
- Reset asserted mid-operation: all state clears immediately, a pending if_rvalid is dropped, and memory contents are not touched.
- Forced loader grant lasts one cycle, then fetch priority resumes.

## Configuration
- IMEM_ALIGN_CHECK_EN defined: a fetch with if_addr[1:0]≠0 is still granted, but returns if_rdata=0 and if_err=1. A loader write with ld_addr[1:0]≠0 is accepted with mem_we=0.
- IMEM_ALIGN_CHECK_EN undefined: addr[1:0] is ignored everywhere, and if_err reflects out-of-range only.

## Test plan
- Reset, then ld writes to 0x0, 0x4, 0x8 with ld_last on 0x8, while if_req=1 throughout. Required: if_ready=0 and core_stall=1 until the cycle after the 0x8 handshake; fetch 0x4 then returns the loaded word one cycle later.
- RUN with if_req and ld_valid continuously high, STARVE_MAX=4. Required: loader granted exactly once every 5 cycles, with core_stall=1 only in those cycles.
- Fetch 0x100 with DEPTH=64 (out-of-range). Required: if_rvalid=1, if_rdata=0, if_err=1. A loader write to 0x100 gives mem_we=0.
- Loader write 0xDEADBEEF to 0x10 in RUN, then fetch 0x10 the next cycle. Required: returns 0xDEADBEEF.
- With IMEM_ALIGN_CHECK_EN, fetch 0x6. Required: if_err=1, if_rdata=0. Without the macro, the same fetch returns word 1 with if_err=0.
- Assert rst while a fetch response is pending. Required: if_rvalid=0 next cycle, state back to BOOT, core_stall=1.
